// File: rtl/disparity_sched_if.sv
// Purpose : handshake/status bundle between disparity_sched and its neighbours
//           (capture buffers, capture FIFOs, disparity core, LEDs).
// Latency : n/a (wires only).
// Backpressure: n/a; flow control is the scheduler's ready/idle gating.
// Modports: master = scheduler side, slave = environment side.
interface disparity_sched_if;
    logic       frame_req;      // request one disparity pass
    logic       left_ready;     // left capture buffer full
    logic       right_ready;    // right capture buffer full
    logic       core_idle;      // disparity core idle
    logic       fifo_rd_l;      // left FIFO read strobe
    logic       fifo_rd_r;      // right FIFO read strobe
    logic       data_sel;       // 0 = left FIFO on image_data, 1 = right
    logic       core_enable;    // one-cycle core start
    logic       core_reset;     // one-cycle core abort
    logic       left_release;   // one-cycle left buffer release
    logic       right_release;  // one-cycle right buffer release
    logic       busy;           // not IDLE
    logic       error;          // sticky watchdog flag
    logic [7:0] frame_count;    // completed passes, wrapping
    logic [2:0] state;          // state encoding for LEDs

    modport master (
        input  frame_req, left_ready, right_ready, core_idle,
        output fifo_rd_l, fifo_rd_r, data_sel, core_enable, core_reset,
               left_release, right_release, busy, error, frame_count, state
    );

    modport slave (
        output frame_req, left_ready, right_ready, core_idle,
        input  fifo_rd_l, fifo_rd_r, data_sel, core_enable, core_reset,
               left_release, right_release, busy, error, frame_count, state
    );
endinterface

// File: rtl/disparity_sched.sv
// Purpose : frame scheduler; arms on both capture buffers full, starts the core,
//           streams left then right frame out of the capture FIFOs, releases buffers.
// Latency : ready -> core_enable 1 cycle; last right read 2*PIXELS cycles later.
// Backpressure: waits in ARM until both buffers are full and the core is idle;
//           one request may queue while busy, further requests are dropped.
// Ports   : clk, reset (sync, active-low) plus bus (disparity_sched_if.master).
// Option  : DISP_SCHED_WATCHDOG_EN enables the COMPUTE watchdog and ABORT path;
//           when undefined COMPUTE waits indefinitely and error is tied low.
module disparity_sched #(
    parameter int WIDTH   = 20,
    parameter int HEIGHT  = 7,
    parameter int PIXELS  = WIDTH * HEIGHT,
    parameter int TIMEOUT = 65535
) (
    input  logic clk,
    input  logic reset,
    disparity_sched_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_LOAD_L  = 3'd2,
        S_LOAD_R  = 3'd3,
        S_COMPUTE = 3'd4,
        S_RELEASE = 3'd5,
        S_ABORT   = 3'd6
    } state_t;

    localparam int              CNT_W    = (PIXELS > 1) ? $clog2(PIXELS) : 1;
    localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(PIXELS - 1);

    // Elaboration-time sanity check on the configuration.
    if (PIXELS < 1 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
        $error("disparity_sched: PIXELS must be >= 1 and TIMEOUT in 1..65535");
    end

    state_t           st;
    logic [CNT_W-1:0] pix_cnt;
    logic             pending;
    logic             seen_busy;
    logic             rd_l_q;
    logic             rd_r_q;
    logic             data_sel_q;
    logic             core_enable_q;
    logic             core_reset_q;
    logic             left_rel_q;
    logic             right_rel_q;
    logic             busy_q;
    logic [7:0]       frame_cnt;
`ifdef DISP_SCHED_WATCHDOG_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);
    logic             error_q;
    logic [15:0]      wd_cnt;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            st            <= S_IDLE;
            pix_cnt       <= '0;
            pending       <= 1'b0;
            seen_busy     <= 1'b0;
            rd_l_q        <= 1'b0;
            rd_r_q        <= 1'b0;
            data_sel_q    <= 1'b0;
            core_enable_q <= 1'b0;
            core_reset_q  <= 1'b0;
            left_rel_q    <= 1'b0;
            right_rel_q   <= 1'b0;
            busy_q        <= 1'b0;
            frame_cnt     <= 8'd0;
`ifdef DISP_SCHED_WATCHDOG_EN
            error_q       <= 1'b0;
            wd_cnt        <= 16'd0;
`endif
        end else begin
            // Pulses default low; they are raised only on the transition edge.
            core_enable_q <= 1'b0;
            core_reset_q  <= 1'b0;
            left_rel_q    <= 1'b0;
            right_rel_q   <= 1'b0;

            // Read strobes trail the state by one cycle so the first read lands
            // in the cycle after core_enable, i.e. the core's first READ cycle.
            rd_l_q     <= (st == S_LOAD_L);
            rd_r_q     <= (st == S_LOAD_R);
            data_sel_q <= (st == S_LOAD_R) || (st == S_COMPUTE);

            // One-deep request queue while a pass is in flight.
            if (st != S_IDLE && bus.frame_req) begin
                pending <= 1'b1;
            end

            case (st)
                S_IDLE: begin
                    if (bus.frame_req || pending) begin
                        st      <= S_ARM;
                        pending <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                S_ARM: begin
                    if (bus.left_ready && bus.right_ready && bus.core_idle) begin
                        st            <= S_LOAD_L;
                        core_enable_q <= 1'b1;
                        pix_cnt       <= '0;
                    end
                end
                S_LOAD_L: begin
                    // Ready inputs are deliberately ignored here: the count alone ends the load.
                    if (pix_cnt == PIX_LAST) begin
                        pix_cnt <= '0;
                        st      <= S_LOAD_R;
                    end else begin
                        pix_cnt <= pix_cnt + 1'b1;
                    end
                end
                S_LOAD_R: begin
                    if (pix_cnt == PIX_LAST) begin
                        pix_cnt   <= '0;
                        st        <= S_COMPUTE;
                        seen_busy <= 1'b0;
`ifdef DISP_SCHED_WATCHDOG_EN
                        wd_cnt    <= 16'd0;
`endif
                    end else begin
                        pix_cnt <= pix_cnt + 1'b1;
                    end
                end
                S_COMPUTE: begin
                    // Completion needs the core to have been seen busy first, so an
                    // idle level left over from before the start does not end the pass.
                    if (!bus.core_idle) begin
                        seen_busy <= 1'b1;
                    end
                    if (bus.core_idle && seen_busy) begin
                        st          <= S_RELEASE;
                        left_rel_q  <= 1'b1;
                        right_rel_q <= 1'b1;
                        frame_cnt   <= frame_cnt + 8'd1;
                        seen_busy   <= 1'b0;
                    end
`ifdef DISP_SCHED_WATCHDOG_EN
                    else if (wd_cnt == WD_LAST) begin
                        // Abort discards the frame: core reset plus both releases.
                        st           <= S_ABORT;
                        core_reset_q <= 1'b1;
                        error_q      <= 1'b1;
                        left_rel_q   <= 1'b1;
                        right_rel_q  <= 1'b1;
                        seen_busy    <= 1'b0;
                    end else begin
                        wd_cnt <= wd_cnt + 16'd1;
                    end
`endif
                end
                S_RELEASE: begin
                    st     <= S_IDLE;
                    busy_q <= 1'b0;
                end
                S_ABORT: begin
                    st     <= S_IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    st     <= S_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.fifo_rd_l     = rd_l_q;
    assign bus.fifo_rd_r     = rd_r_q;
    assign bus.data_sel      = data_sel_q;
    assign bus.core_enable   = core_enable_q;
    assign bus.core_reset    = core_reset_q;
    assign bus.left_release  = left_rel_q;
    assign bus.right_release = right_rel_q;
    assign bus.busy          = busy_q;
    assign bus.frame_count   = frame_cnt;
    assign bus.state         = st;
`ifdef DISP_SCHED_WATCHDOG_EN
    assign bus.error         = error_q;
`else
    assign bus.error         = 1'b0;
`endif

endmodule
